// File: rtl/onehot_select_seq.sv
// -----------------------------------------------------------------------------
// onehot_select_seq
//
// Registered binary-to-one-hot select generator with a valid/ready input
// handshake. Three output modes:
//   00 latch : hold onehot(sel) until replaced or cleared
//   01 pulse : drive onehot(sel) for PULSE_LEN enabled cycles, then 0 + done
//   10 scan  : start at onehot(sel), rotate left once per enabled cycle so
//              every line is visited exactly once, then 0 + done
//   11       : reserved; accepted, drives 0 and raises err for one cycle
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   en_i         global enable; low freezes state, counter and out
//   clr_i        synchronous clear to IDLE, wins over any accept
//   in_valid_i   request valid
//   in_ready_o   request can be accepted this cycle (combinational)
//   in_sel_i     line index
//   in_mode_i    operating mode
//   out_o        registered one-hot (or all-zero) select lines
//   busy_o       a pulse or scan is in progress
//   done_o       one-cycle pulse when a pulse/scan completes
//   err_o        one-cycle pulse when the reserved mode is accepted
// -----------------------------------------------------------------------------
module onehot_select_seq #(
   parameter  int SEL_W     = 3,
   parameter  int PULSE_LEN = 4,
   localparam int OUT_W     = 2 ** SEL_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [SEL_W-1:0] in_sel_i,
   input  logic [1:0]       in_mode_i,
   output logic [OUT_W-1:0] out_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   // Counter must hold the larger of the two reload values.
   localparam int MAX_LEN = (PULSE_LEN > OUT_W) ? PULSE_LEN : OUT_W;
   localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] SCAN_LOAD  = CNT_W'(OUT_W - 1);

   localparam logic [1:0] MODE_LATCH = 2'b00;
   localparam logic [1:0] MODE_PULSE = 2'b01;
   localparam logic [1:0] MODE_SCAN  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_PULSE = 2'd2,
      ST_SCAN  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [OUT_W-1:0]   out_q,   out_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               done_q,  done_d;
   logic               err_q,   err_d;

   logic [OUT_W-1:0]   sel_onehot;
   logic               accept;

   // Binary-to-one-hot decode of the request index.
   generate
      for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
         assign sel_onehot[gi] = (in_sel_i == SEL_W'(gi));
      end
   endgenerate

   // rst_ni is folded in so in_ready reads low throughout reset, even though
   // the state register already sits at IDLE.
   assign in_ready_o = rst_ni & en_i & ~clr_i &
                       ((state_q == ST_IDLE) || (state_q == ST_LATCH));
   assign accept     = in_valid_i & in_ready_o;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      if (clr_i) begin
         state_d = ST_IDLE;
         out_d   = '0;
         cnt_d   = '0;
      end else if (en_i) begin
         case (state_q)
            ST_IDLE, ST_LATCH: begin
               if (accept) begin
                  case (in_mode_i)
                     MODE_LATCH: begin
                        state_d = ST_LATCH;
                        out_d   = sel_onehot;
                     end
                     MODE_PULSE: begin
                        state_d = ST_PULSE;
                        out_d   = sel_onehot;
                        cnt_d   = PULSE_LOAD;
                     end
                     MODE_SCAN: begin
                        state_d = ST_SCAN;
                        out_d   = sel_onehot;
                        cnt_d   = SCAN_LOAD;
                     end
                     default: begin
                        state_d = ST_IDLE;
                        out_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                     end
                  endcase
               end
            end
            ST_PULSE: begin
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
                  out_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_SCAN: begin
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
                  out_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
                  // Rotate left, top line wraps to line 0.
                  out_d = {out_q[OUT_W-2:0], out_q[OUT_W-1]};
               end
            end
            default: begin
               state_d = ST_IDLE;
               out_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         out_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign out_o  = out_q;
   assign busy_o = (state_q == ST_PULSE) || (state_q == ST_SCAN);
   assign done_o = done_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_onehot_select_seq.sv
// -----------------------------------------------------------------------------
// tb_onehot_select_seq
//
// Directed bench for onehot_select_seq with SEL_W = 3, PULSE_LEN = 4.
// Inputs change 2 time units after each rising edge; outputs are sampled
// 1 time unit later, well clear of both clock edges.
// -----------------------------------------------------------------------------
module tb_onehot_select_seq;

   localparam int SEL_W     = 3;
   localparam int PULSE_LEN = 4;
   localparam int OUT_W     = 2 ** SEL_W;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             en_i;
   logic             clr_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [SEL_W-1:0] in_sel_i;
   logic [1:0]       in_mode_i;
   logic [OUT_W-1:0] out_o;
   logic             busy_o;
   logic             done_o;
   logic             err_o;

   int n_checks = 0;
   int n_errors = 0;

   onehot_select_seq #(
      .SEL_W     (SEL_W),
      .PULSE_LEN (PULSE_LEN)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (en_i),
      .clr_i      (clr_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_sel_i   (in_sel_i),
      .in_mode_i  (in_mode_i),
      .out_o      (out_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic request(input logic [SEL_W-1:0] sel, input logic [1:0] mode);
      in_valid_i = 1'b1;
      in_sel_i   = sel;
      in_mode_i  = mode;
      tick();
      in_valid_i = 1'b0;
      #1;
   endtask

   logic [OUT_W-1:0] scan_exp [8];
   int n;

   initial begin
      scan_exp[0] = 8'h40; scan_exp[1] = 8'h80; scan_exp[2] = 8'h01; scan_exp[3] = 8'h02;
      scan_exp[4] = 8'h04; scan_exp[5] = 8'h08; scan_exp[6] = 8'h10; scan_exp[7] = 8'h20;

      // ---------------- reset / idle ----------------
      rst_ni     = 1'b0;
      en_i       = 1'b1;
      clr_i      = 1'b0;
      in_valid_i = 1'b0;
      in_sel_i   = '0;
      in_mode_i  = 2'b00;
      tick();
      tick();
      #1;
      chk("rst_out",      32'(out_o),      32'h00);
      chk("rst_busy",     32'(busy_o),     32'h0);
      chk("rst_done",     32'(done_o),     32'h0);
      chk("rst_err",      32'(err_o),      32'h0);
      chk("rst_ready",    32'(in_ready_o), 32'h0);
      tick();
      rst_ni = 1'b1;
      #1;
      chk("rel_ready",    32'(in_ready_o), 32'h1);
      chk("rel_out",      32'(out_o),      32'h00);

      // ---------------- latch then replace ----------------
      request(3'd5, 2'b00);
      chk("latch5_c1",    32'(out_o),      32'h20);
      chk("latch5_busy",  32'(busy_o),     32'h0);
      chk("latch5_ready", 32'(in_ready_o), 32'h1);
      tick(); #1;
      chk("latch5_c2",    32'(out_o),      32'h20);
      tick(); #1;
      chk("latch5_c3",    32'(out_o),      32'h20);
      request(3'd2, 2'b00);
      chk("latch2_nozero", 32'(out_o),     32'h04);

      // ---------------- pulse from latch ----------------
      request(3'd7, 2'b01);
      for (int i = 0; i < PULSE_LEN; i++) begin
         chk($sformatf("pulse_out_%0d", i),   32'(out_o),      32'h80);
         chk($sformatf("pulse_busy_%0d", i),  32'(busy_o),     32'h1);
         chk($sformatf("pulse_ready_%0d", i), 32'(in_ready_o), 32'h0);
         tick(); #1;
      end
      chk("pulse_end_out",   32'(out_o),      32'h00);
      chk("pulse_end_done",  32'(done_o),     32'h1);
      chk("pulse_end_ready", 32'(in_ready_o), 32'h1);
      chk("pulse_end_busy",  32'(busy_o),     32'h0);
      tick(); #1;
      chk("pulse_done_drop", 32'(done_o),     32'h0);

      // ---------------- pulse with a 2-cycle stall ----------------
      request(3'd7, 2'b01);
      n = 0;
      while (out_o == 8'h80 && n < 20) begin
         n++;
         if (n == 2) en_i = 1'b0;
         if (n == 4) en_i = 1'b1;
         tick(); #1;
      end
      chk("stall_len",       32'(n),          32'd6);
      chk("stall_done",      32'(done_o),     32'h1);
      chk("stall_out",       32'(out_o),      32'h00);
      tick(); #1;

      // ---------------- scan with wrap ----------------
      request(3'd6, 2'b10);
      for (int i = 0; i < OUT_W; i++) begin
         chk($sformatf("scan_out_%0d", i), 32'(out_o),  32'(scan_exp[i]));
         chk($sformatf("scan_done_%0d", i), 32'(done_o), 32'h0);
         tick(); #1;
      end
      chk("scan_end_out",    32'(out_o),      32'h00);
      chk("scan_end_done",   32'(done_o),     32'h1);
      tick(); #1;

      // ---------------- clear during scan cycle 3 ----------------
      request(3'd0, 2'b10);
      chk("clrscan_c1",      32'(out_o),      32'h01);
      tick(); #1;
      chk("clrscan_c2",      32'(out_o),      32'h02);
      tick(); #1;
      chk("clrscan_c3",      32'(out_o),      32'h04);
      clr_i = 1'b1;
      #1;
      tick();
      clr_i = 1'b0;
      #1;
      chk("clrscan_out",     32'(out_o),      32'h00);
      chk("clrscan_done",    32'(done_o),     32'h0);
      chk("clrscan_busy",    32'(busy_o),     32'h0);
      chk("clrscan_ready",   32'(in_ready_o), 32'h1);

      // ---------------- reserved mode ----------------
      request(3'd1, 2'b11);
      chk("rsv_out",         32'(out_o),      32'h00);
      chk("rsv_err",         32'(err_o),      32'h1);
      chk("rsv_busy",        32'(busy_o),     32'h0);
      tick(); #1;
      chk("rsv_err_drop",    32'(err_o),      32'h0);

      // ---------------- clr together with in_valid ----------------
      clr_i = 1'b1;
      #1;
      chk("clrval_ready",    32'(in_ready_o), 32'h0);
      request(3'd3, 2'b00);
      clr_i = 1'b0;
      #1;
      chk("clrval_out",      32'(out_o),      32'h00);

      // ---------------- clr wins while en is low ----------------
      request(3'd1, 2'b00);
      chk("clren_latch",     32'(out_o),      32'h02);
      en_i  = 1'b0;
      clr_i = 1'b1;
      tick();
      en_i  = 1'b1;
      clr_i = 1'b0;
      #1;
      chk("clren_out",       32'(out_o),      32'h00);

      // ---------------- async reset mid-pulse ----------------
      request(3'd4, 2'b01);
      chk("arst_pre",        32'(out_o),      32'h10);
      rst_ni = 1'b0;
      #1;
      chk("arst_out",        32'(out_o),      32'h00);
      chk("arst_busy",       32'(busy_o),     32'h0);
      chk("arst_ready",      32'(in_ready_o), 32'h0);
      tick();
      rst_ni = 1'b1;
      #1;
      chk("arst_rel_ready",  32'(in_ready_o), 32'h1);
      chk("arst_rel_busy",   32'(busy_o),     32'h0);
      request(3'd3, 2'b00);
      chk("arst_first_acc",  32'(out_o),      32'h08);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
